// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus bundle: pipeline, long-latency unit, issue/scoreboard
// query and register-file write port. master = upstream/environment, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_hold;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_waddr;
  logic [DW-1:0] lu_wdata;
  logic          issue_valid;
  logic [4:0]    issue_waddr;
  logic          sb_conflict;
  logic [4:0]    query_addr1;
  logic [4:0]    query_addr2;
  logic          busy1;
  logic          busy2;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] fifo_count;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
           issue_valid, issue_waddr, query_addr1, query_addr2,
    input  pipe_hold, lu_ready, sb_conflict, busy1, busy2,
           rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
           issue_valid, issue_waddr, query_addr1, query_addr2,
    output pipe_hold, lu_ready, sb_conflict, busy1, busy2,
           rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges in-order pipeline write-back (priority) and a FIFO-buffered long-latency
// unit onto the single register-file write port; tracks per-register busy bits.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int DW         = 32
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [31:0]   busy, busy_next;
  logic          rf_we, sb_conflict;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pipe_req, push, pop, issue_set, empty;

  assign empty     = (count == '0);
  assign pipe_req  = bus.pipe_we && (bus.pipe_waddr != 5'd0);
  assign bus.lu_ready = !reset && (count < CW'(DEPTH));
  // Writes to r0 complete the handshake but are dropped here.
  assign push      = bus.lu_valid && bus.lu_ready && (bus.lu_waddr != 5'd0);
  assign pop       = !pipe_req && !empty;
  assign issue_set = bus.issue_valid && (bus.issue_waddr != 5'd0);

  // Set beats clear when an issue and a pop name the same register.
  always_comb begin
    busy_next = busy;
    if (pop)       busy_next[q_addr[rd_ptr]] = 1'b0;
    if (issue_set) busy_next[bus.issue_waddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.lu_waddr;
      q_data[wr_ptr] <= bus.lu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve      <= '0;
      busy        <= '0;
      sb_conflict <= 1'b0;
    end else begin
      if (pipe_req) begin
        rf_we    <= 1'b1;
        rf_waddr <= bus.pipe_waddr;
        rf_wdata <= bus.pipe_wdata;
      end else if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= q_addr[rd_ptr];
        rf_wdata <= q_data[rd_ptr];
      end else begin
        rf_we    <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (pop || empty)
        starve <= '0;
      else if (pipe_req && starve != SW'(STARVE_MAX))
        starve <= starve + SW'(1);
      busy        <= busy_next;
      sb_conflict <= issue_set && busy[bus.issue_waddr];
    end
  end

  assign bus.rf_we       = rf_we;
  assign bus.rf_waddr    = rf_waddr;
  assign bus.rf_wdata    = rf_wdata;
  assign bus.fifo_count  = count;
  assign bus.pipe_hold   = (starve == SW'(STARVE_MAX));
  assign bus.sb_conflict = sb_conflict;
  assign bus.busy1       = busy[bus.query_addr1];
  assign bus.busy2       = busy[bus.query_addr2];
endmodule
